// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter that lets NCORES requesters share one
//            single-port synchronous RAM (1-cycle read latency). Each granted
//            transaction walks ISSUE -> WAIT -> DONE and then returns to IDLE.
// Ports    : clk, rstn          clock / asynchronous active-low reset
//            req, we            per-core request and write qualifier
//            addr, wdata        per-core packed address / write data
//            gnt, done          one-hot grant (whole transaction) / done pulse
//            rdata              read data broadcast, valid while done is high
//            ram_addr, ram_din  registered RAM address / write data
//            ram_wren           registered RAM write enable
//            ram_q              RAM read data
// Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    done,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    input  logic [DW-1:0]        ram_q
);

    localparam int c_IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [c_IW:0] c_N = NCORES[c_IW:0];

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_IW-1:0]   r_win;
    logic [c_IW-1:0]   r_last;
    logic              r_we;

    logic              w_found;
    logic [c_IW-1:0]   w_win;
    logic [c_IW:0]     w_sum;
    logic [c_IW-1:0]   w_cand;
    logic [NCORES-1:0] w_onehot;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic              w_sel_we;

    // Round-robin search starting just after the last served core. The sum
    // carries one spare bit so the wrap works for non-power-of-two NCORES.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NCORES; k++) begin
            w_sum = {1'b0, r_last} + (c_IW+1)'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_cand = w_sum[c_IW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Pick the winner's request fields out of the packed input buses.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_win == c_IW'(i)) begin
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_wdata = wdata[i*DW +: DW];
                w_sel_we    = we[i];
            end
        end
    end

    assign w_onehot = NCORES'(1) << r_win;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and decoded outputs. gnt/done are decoded from state so an
    // asynchronous reset clears them immediately.
    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        done        = '0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                gnt         = w_onehot;
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                gnt         = w_onehot;
                w_state_nxt = c_DONE;
            end
            c_DONE: begin
                gnt         = w_onehot;
                done        = w_onehot;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Transaction datapath. The RAM address/data registers double as the
    // latched request: they load only on IDLE->ISSUE and hold afterwards, so
    // later input churn cannot reach the RAM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win    <= '0;
            r_last   <= c_IW'(NCORES - 1);
            r_we     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
            rdata    <= '0;
        end else begin
            ram_wren <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_win    <= w_win;
                        r_we     <= w_sel_we;
                        ram_addr <= w_sel_addr;
                        ram_din  <= w_sel_wdata;
                        ram_wren <= w_sel_we;
                    end
                end
                c_WAIT: begin
                    // ram_q reflects the address issued one cycle earlier.
                    if (!r_we) begin
                        rdata <= ram_q;
                    end
                end
                c_DONE: begin
                    r_last <= r_win;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a synchronous RAM model
//            and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int NCORES = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req  = '0;
    logic [3:0]  we   = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rdata;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wren;
    logic [7:0]  ram_q;

    // Backdoor preload port into both the RAM and the reference memory
    logic        bd_we   = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [7:0]  bd_data = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NCORES(NCORES), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    // Synchronous RAM, one-cycle read latency
    logic [7:0] ram [256];
    always @(posedge clk) begin
        ram_q <= ram[ram_addr];
        if (ram_wren) ram[ram_addr] <= ram_din;
        if (bd_we)    ram[bd_addr]  <= bd_data;
    end

    // ---------------- reference model (transaction level) ----------------
    // A granted transaction occupies the bus for three cycles; m_busy counts
    // the remaining cycles (3 = address phase, 1 = completion cycle).
    logic [7:0] ref_mem [256];
    int         m_busy, m_w, m_last, m_pick;
    logic       m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;

    function automatic int rr_pick(int last, logic [3:0] r);
        for (int k = 1; k <= NCORES; k++) begin
            int idx;
            idx = (last + k) % NCORES;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy  <= 0;
            m_w     <= 0;
            m_last  <= NCORES - 1;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else begin
            if (bd_we) ref_mem[bd_addr] <= bd_data;
            if (m_busy == 0) begin
                if (req != 4'b0000) begin
                    m_pick   = rr_pick(m_last, req);
                    m_w     <= m_pick;
                    m_we    <= we[m_pick];
                    m_addr  <= addr[m_pick*8 +: 8];
                    m_wdata <= wdata[m_pick*8 +: 8];
                    m_busy  <= 3;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 3 && m_we)  ref_mem[m_addr] <= m_wdata;
                if (m_busy == 2 && !m_we) m_rdata <= ref_mem[m_addr];
                if (m_busy == 1)          m_last <= m_w;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_checks++;
        if (gnt !== 4'b0 || done !== 4'b0 || ram_wren !== 1'b0)
            $display("FAIL reset_ctrl: gnt=%b done=%b wren=%b, expected all zero", gnt, done, ram_wren);
        else n_pass++;
        n_checks++;
        if (ram_addr !== 8'h00 || ram_din !== 8'h00 || rdata !== 8'h00)
            $display("FAIL reset_data: addr=%h din=%h rdata=%h, expected 00", ram_addr, ram_din, rdata);
        else n_pass++;
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0 || ram_wren !== 1'b0)
            $display("FAIL reset_hold: gnt=%b wren=%b, expected 0 while rstn low", gnt, ram_wren);
        else n_pass++;
        req  = 4'b0000;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0)
            $display("FAIL reset_idle: gnt=%b, expected 0000", gnt);
        else n_pass++;
    endtask

    task automatic preload();
        for (int a = 0; a < 256; a++) begin
            bd_we   = 1'b1;
            bd_addr = 8'(a);
            bd_data = 8'($urandom);
            @(negedge clk);
        end
        bd_we = 1'b0;
    endtask

    task automatic test_single_read();
        bd_we = 1'b1; bd_addr = 8'h15; bd_data = 8'hA7;
        @(negedge clk);
        bd_we = 1'b0;
        req = 4'b0100; we = 4'b0000; addr[23:16] = 8'h15;
        @(negedge clk); // cycle 1
        n_checks++;
        if (gnt !== 4'b0100 || ram_addr !== 8'h15 || done !== 4'b0)
            $display("FAIL read_c1: gnt=%b addr=%h done=%b, expected 0100/15/0000", gnt, ram_addr, done);
        else n_pass++;
        @(negedge clk); // cycle 2
        n_checks++;
        if (gnt !== 4'b0100 || done !== 4'b0)
            $display("FAIL read_c2: gnt=%b done=%b, expected 0100/0000", gnt, done);
        else n_pass++;
        @(negedge clk); // cycle 3
        n_checks++;
        if (gnt !== 4'b0100 || done !== 4'b0100 || rdata !== 8'hA7)
            $display("FAIL read_c3: gnt=%b done=%b rdata=%h, expected 0100/0100/a7", gnt, done, rdata);
        else n_pass++;
        req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0 || done !== 4'b0)
            $display("FAIL read_c4: gnt=%b done=%b, expected 0000/0000", gnt, done);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int wc;
        wc  = 0;
        req = 4'b0001; we = 4'b0001; addr[7:0] = 8'h40; wdata[7:0] = 8'h3C;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (ram_wren === 1'b1) wc++;
            if (c == 3) begin
                n_checks++;
                if (done !== 4'b0001 || rdata !== 8'hA7)
                    $display("FAIL write_done: done=%b rdata=%h, expected 0001/a7", done, rdata);
                else n_pass++;
            end
        end
        n_checks++;
        if (wc != 1) $display("FAIL write_wren_cycles: got %0d, expected 1", wc);
        else n_pass++;
        req = 4'b0000;
        @(negedge clk);
        wc  = 0;
        req = 4'b0001; we = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (ram_wren === 1'b1) wc++;
            if (c == 3) begin
                n_checks++;
                if (done !== 4'b0001 || rdata !== 8'h3C)
                    $display("FAIL readback: done=%b rdata=%h, expected 0001/3c", done, rdata);
                else n_pass++;
            end
        end
        n_checks++;
        if (wc != 0) $display("FAIL read_wren_cycles: got %0d, expected 0", wc);
        else n_pass++;
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int order [4];
        int when  [4];
        int n;
        bit bad;
        n = 0; bad = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        req = 4'b1111; we = 4'b0000; addr = 32'h0403_0201;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (!$onehot0(gnt) || !$onehot0(done)) bad = 1'b1;
            if (done != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (done[i]) order[n] = i;
                when[n] = c;
                n++;
                req = req & ~done;
            end
        end
        req = 4'b0000;
        n_checks++;
        if (n != 4) $display("FAIL contention_timeout: %0d dones seen, expected 4", n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (order[i] != i) $display("FAIL contention_order[%0d]: core %0d, expected %0d", i, order[i], i);
            else n_pass++;
        end
        if (n > 0) begin
            n_checks++;
            if (when[0] != 3) $display("FAIL contention_first: cycle %0d, expected 3", when[0]);
            else n_pass++;
        end
        for (int i = 1; i < n; i++) begin
            n_checks++;
            if (when[i] - when[i-1] != 4)
                $display("FAIL contention_spacing[%0d]: %0d cycles, expected 4", i, when[i] - when[i-1]);
            else n_pass++;
        end
        n_checks++;
        if (bad) $display("FAIL contention_onehot: gnt/done not one-hot, expected one-hot or zero");
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0] seq     [5];
        logic [3:0] exp_seq [5];
        int n;
        exp_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001};
        n   = 0;
        req = 4'b1010; we = 4'b0000;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (done != 4'b0000) begin
                seq[n] = done;
                n++;
                if (n == 3) req[0] = 1'b1;
                if (done[0]) req[0] = 1'b0;
            end
        end
        req = 4'b0000;
        n_checks++;
        if (n != 5) $display("FAIL fairness_timeout: %0d dones seen, expected 5", n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (seq[i] !== exp_seq[i])
                $display("FAIL fairness_seq[%0d]: done=%b, expected %b", i, seq[i], exp_seq[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit bad;
        bad = 1'b0;
        // completed core-1 read so that the pointer sits on core 1
        req = 4'b0010; we = 4'b0000; addr[15:8] = 8'h10;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++;
        if (done !== 4'b0010) $display("FAIL abort_pre_done: done=%b, expected 0010", done);
        else n_pass++;
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk); // ISSUE
        @(negedge clk); // WAIT
        rstn = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0 || done !== 4'b0 || ram_wren !== 1'b0 || ram_addr !== 8'h00)
            $display("FAIL abort_async: gnt=%b done=%b wren=%b addr=%h, expected 0000/0000/0/00",
                     gnt, done, ram_wren, ram_addr);
        else n_pass++;
        req = 4'b0110;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (done !== 4'b0 || gnt !== 4'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL abort_hold: done/gnt active during reset, expected 0");
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) $display("FAIL abort_regrant: gnt=%b, expected 0010", gnt);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (done !== 4'b0010) $display("FAIL abort_redone: done=%b, expected 0010", done);
        else n_pass++;
        req = 4'b0100;
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++;
        if (done !== 4'b0100) $display("FAIL abort_next: done=%b, expected 0100", done);
        else n_pass++;
        req = 4'b0000;
        @(negedge clk);
        // write aborted during ISSUE: the write enable must drop at once
        req = 4'b1000; we = 4'b1000; addr[31:24] = 8'h20; wdata[31:24] = 8'h5E;
        @(negedge clk);
        n_checks++;
        if (ram_wren !== 1'b1) $display("FAIL abort_wr_issue: wren=%b, expected 1", ram_wren);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (ram_wren !== 1'b0 || gnt !== 4'b0)
            $display("FAIL abort_wr_async: wren=%b gnt=%b, expected 0/0000", ram_wren, gnt);
        else n_pass++;
        req = 4'b0000; we = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_churn();
        bd_we = 1'b1; bd_addr = 8'h77; bd_data = 8'h00;
        @(negedge clk);
        bd_we = 1'b0;
        req = 4'b0001; we = 4'b0001; addr[7:0] = 8'h33; wdata[7:0] = 8'h99;
        @(negedge clk); // ISSUE
        n_checks++;
        if (ram_addr !== 8'h33 || ram_din !== 8'h99 || ram_wren !== 1'b1)
            $display("FAIL churn_issue: addr=%h din=%h wren=%b, expected 33/99/1", ram_addr, ram_din, ram_wren);
        else n_pass++;
        addr[7:0] = 8'h77; wdata[7:0] = 8'h11; req = 4'b0000;
        @(negedge clk); // WAIT
        n_checks++;
        if (ram_addr !== 8'h33 || ram_wren !== 1'b0 || gnt !== 4'b0001)
            $display("FAIL churn_wait: addr=%h wren=%b gnt=%b, expected 33/0/0001", ram_addr, ram_wren, gnt);
        else n_pass++;
        @(negedge clk); // DONE
        n_checks++;
        if (done !== 4'b0001) $display("FAIL churn_done: done=%b, expected 0001", done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ram[8'h77] !== 8'h00) $display("FAIL churn_stray: ram[77]=%h, expected 00", ram[8'h77]);
        else n_pass++;
        req = 4'b0001; we = 4'b0000; addr[7:0] = 8'h33;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++;
        if (done !== 4'b0001 || rdata !== 8'h99)
            $display("FAIL churn_readback: done=%b rdata=%h, expected 0001/99", done, rdata);
        else n_pass++;
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] e_gnt, e_done;
        logic       e_wren;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            e_gnt  = (m_busy > 0)  ? (4'b0001 << m_w) : 4'b0000;
            e_done = (m_busy == 1) ? (4'b0001 << m_w) : 4'b0000;
            e_wren = (m_busy == 3) && m_we;
            n_checks++;
            if (gnt !== e_gnt || done !== e_done || ram_wren !== e_wren ||
                ram_addr !== m_addr || ram_din !== m_wdata || rdata !== m_rdata)
                $display("FAIL random_c%0d: gnt=%b/%b done=%b/%b wren=%b/%b addr=%h/%h din=%h/%h rdata=%h/%h (got/expected)",
                         c, gnt, e_gnt, done, e_done, ram_wren, e_wren, ram_addr, m_addr,
                         ram_din, m_wdata, rdata, m_rdata);
            else n_pass++;
            for (int i = 0; i < NCORES; i++) begin
                if (req[i] && done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i]          = 1'b1;
                        we[i]           = 1'($urandom_range(0, 1));
                        addr[i*8 +: 8]  = 8'($urandom_range(0, 15));
                        wdata[i*8 +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    addr[i*8 +: 8]  = 8'($urandom_range(0, 15));
                    wdata[i*8 +: 8] = 8'($urandom);
                end
            end
        end
        req = 4'b0000;
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        preload();
        test_single_read();
        test_write_read();
        test_contention();
        test_fairness();
        test_abort();
        test_churn();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
